// File: rtl/wave_phase_counter_pkg.sv
// wave_phase_counter_pkg: shared widths and Q0.7 reference constants for the wave generator
package wave_phase_counter_pkg;
  localparam int N_FRAC_DEF = 7;
  localparam logic [N_FRAC_DEF:0] ONE       = 8'b0111_1111;
  localparam logic [N_FRAC_DEF:0] MINUS_ONE = 8'b1000_0001;
endpackage

// File: rtl/wave_phase_counter_prescaler.sv
// strobe_prescaler: sample-rate tick generator, one tick every div_i+1 enabled cycles
module strobe_prescaler
  import wave_phase_counter_pkg::*;
#(
  parameter int N_DIV = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic [N_DIV-1:0] div_i,
  output logic             tick_o
);
  logic [N_DIV-1:0] div_cnt;
  // >= so that lowering div_i below the running count ticks on the next enabled cycle
  assign tick_o = enable_i && (div_cnt >= div_i);
  // count enabled cycles, restart at each tick
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) div_cnt <= '0;
    else if (tick_o) div_cnt <= '0;
    else if (enable_i) div_cnt <= div_cnt + 1'b1;
endmodule

// File: rtl/wave_phase_counter.sv
// wave_phase_counter: phase accumulator with phase-continuous tuning-word updates
module wave_phase_counter
  import wave_phase_counter_pkg::*;
#(
  parameter int                N_FRAC    = N_FRAC_DEF,
  parameter int                N_ACC     = 16,
  parameter int                N_DIV     = 8,
  parameter logic [N_ACC-1:0]  RESET_INC = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic [N_DIV-1:0]         div_i,
  input  logic [N_ACC-1:0]         freq_word_i,
  input  logic                     freq_word_valid_i,
  output logic                     freq_word_ready_o,
  output logic signed [N_FRAC:0]   counter_value_o,
  output logic                     counter_value_valid_strobe_o,
  output logic                     wrap_strobe_o
);
  logic             tick;
  logic [N_ACC-1:0] acc, inc_active, shadow;
  logic             pending;
  logic [N_ACC:0]   sum;
  strobe_prescaler #(.N_DIV(N_DIV)) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .div_i    (div_i),
    .tick_o   (tick)
  );
  assign sum = {1'b0, acc} + {1'b0, inc_active};
  assign freq_word_ready_o = !pending;
  // advance phase per tick; new increment swaps in only on a wrapping (or idle) tick
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      acc                          <= '0;
      inc_active                   <= RESET_INC;
      shadow                       <= '0;
      pending                      <= 1'b0;
      counter_value_o              <= '0;
      counter_value_valid_strobe_o <= 1'b0;
      wrap_strobe_o                <= 1'b0;
    end else begin
      counter_value_valid_strobe_o <= tick;
      wrap_strobe_o                <= tick && sum[N_ACC];
      if (tick) begin
        acc             <= sum[N_ACC-1:0];
        counter_value_o <= sum[N_ACC-1 -: N_FRAC+1];
      end
      if (tick && pending && (sum[N_ACC] || inc_active == '0)) begin
        inc_active <= shadow;
        pending    <= 1'b0;
      end else if (freq_word_valid_i && !pending) begin
        shadow  <= freq_word_i;
        pending <= 1'b1;
      end
    end
endmodule

// File: tb/tb_wave_phase_counter.sv
// tb_wave_phase_counter: directed checks of tick timing, ramp, wrap and tuning handshake
module tb_wave_phase_counter;
  logic              clk = 1'b0;
  logic              rst_i, enable, valid, ready, strobe, wrap;
  logic [7:0]        div;
  logic [15:0]       word;
  logic signed [7:0] value;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wave_phase_counter #(.N_FRAC(7), .N_ACC(16), .N_DIV(8), .RESET_INC(16'h0000)) dut (
    .clk_i                        (clk),
    .rst_i                        (rst_i),
    .enable_i                     (enable),
    .div_i                        (div),
    .freq_word_i                  (word),
    .freq_word_valid_i            (valid),
    .freq_word_ready_o            (ready),
    .counter_value_o              (value),
    .counter_value_valid_strobe_o (strobe),
    .wrap_strobe_o                (wrap)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int q07(input int k);
    int r = k % 256;
    return (r >= 128) ? r - 256 : r;
  endfunction

  task automatic expect_tick(input string tag, input int val, input int w);
    chk({tag, "_strobe"}, int'(strobe), 1);
    chk({tag, "_value"}, int'(value), val);
    chk({tag, "_wrap"}, int'(wrap), w);
  endtask

  initial begin
    rst_i = 1'b0; enable = 1'b0; valid = 1'b0; div = 8'd0; word = 16'h0;
    #1;
    chk("por_value", int'(value), 0);
    chk("por_strobe", int'(strobe), 0);
    chk("por_ready", int'(ready), 1);
    @(negedge clk); rst_i = 1'b1;
    // idle increment: offer 0x4000 while disabled, it stays pending
    @(negedge clk); valid = 1'b1; word = 16'h4000;
    @(negedge clk); valid = 1'b0;
    chk("t5_ready_low", int'(ready), 0);
    repeat (3) @(negedge clk);
    chk("t5_pending_held", int'(ready), 0);
    chk("t5_no_strobe", int'(strobe), 0);
    enable = 1'b1;
    @(negedge clk); expect_tick("t5_apply", 0, 0);
    chk("t5_ready_back", int'(ready), 1);
    @(negedge clk); expect_tick("t5_v1", 64, 0);
    @(negedge clk); expect_tick("t5_v2", -128, 0);
    @(negedge clk); expect_tick("t5_v3", -64, 0);
    @(negedge clk); expect_tick("t5_v4", 0, 1);
    // switch to 0x0100 mid-cycle: holds until the next wrap
    valid = 1'b1; word = 16'h0100;
    @(negedge clk); valid = 1'b0;
    expect_tick("sw_v1", 64, 0);
    chk("sw_ready_low", int'(ready), 0);
    @(negedge clk); expect_tick("sw_v2", -128, 0);
    @(negedge clk); expect_tick("sw_v3", -64, 0);
    @(negedge clk); expect_tick("sw_wrap", 0, 1);
    chk("sw_ready_back", int'(ready), 1);
    // full ramp at div=3
    div = 8'd3;
    for (int i = 1; i <= 257; i++) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        chk("t2_gap_strobe", int'(strobe), 0);
        chk("t2_gap_hold", int'(value), q07(i - 1));
      end
      @(negedge clk);
      expect_tick("t2_ramp", q07(i), (i == 256) ? 1 : 0);
    end
    // freeze at div_cnt=2
    repeat (2) @(negedge clk);
    chk("t6_pre_strobe", int'(strobe), 0);
    enable = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("t6_frozen_strobe", int'(strobe), 0);
      chk("t6_frozen_value", int'(value), 1);
    end
    enable = 1'b1;
    @(negedge clk); chk("t6_resume_gap", int'(strobe), 0);
    @(negedge clk); expect_tick("t6_resume", 2, 0);
    // div=0 every cycle, then lower div below the count
    div = 8'd0;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk); expect_tick("t3_fast", k, 0);
    end
    div = 8'd5;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("t3_div5_gap", int'(strobe), 0);
    end
    div = 8'd1;
    @(negedge clk); expect_tick("t3_div_drop", 6, 0);
    // phase-continuous change from 0x0100 to 0x0800 at acc=0x1000
    div = 8'd0;
    for (int k = 7; k <= 16; k++) begin
      @(negedge clk); expect_tick("t4_run", k, 0);
    end
    valid = 1'b1; word = 16'h0800;
    @(negedge clk); valid = 1'b0;
    expect_tick("t4_accept", 17, 0);
    chk("t4_ready_low", int'(ready), 0);
    for (int k = 18; k <= 256; k++) begin
      @(negedge clk);
      expect_tick("t4_old_inc", q07(k), (k == 256) ? 1 : 0);
      chk("t4_ready", int'(ready), (k == 256) ? 1 : 0);
    end
    @(negedge clk); expect_tick("t4_new_inc1", 8, 0);
    @(negedge clk); expect_tick("t4_new_inc2", 16, 0);
    for (int k = 3; k <= 7; k++) @(negedge clk);
    chk("t1_pre_value", int'(value), 56);
    // reset mid-run with a word pending
    valid = 1'b1; word = 16'h0800;
    @(negedge clk); valid = 1'b0;
    chk("t1_pending", int'(ready), 0);
    chk("t1_pre_reset_value", int'(value), 64);
    #2 rst_i = 1'b0;
    #1;
    chk("t1_async_value", int'(value), 0);
    chk("t1_async_strobe", int'(strobe), 0);
    chk("t1_async_wrap", int'(wrap), 0);
    chk("t1_async_ready", int'(ready), 1);
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); expect_tick("t1_after", 0, 0);
    chk("t1_discarded", int'(ready), 1);
    valid = 1'b1; word = 16'h0200;
    @(negedge clk); valid = 1'b0;
    expect_tick("t1_accept", 0, 0);
    @(negedge clk); expect_tick("t1_apply", 0, 0);
    chk("t1_ready_back", int'(ready), 1);
    @(negedge clk); expect_tick("t1_first", 2, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
